// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer: valid/ready pipeline register with 2-entry skid, flush-to-bubble and freeze.
// Optional stall/bubble statistics counters are enabled by defining PIPE_STAGE_BUFFER_STATS_EN.
module pipe_stage_buffer #(
    parameter int                 NB_DATA     = 128,
    parameter int                 NB_CTRL     = 12,
    parameter logic [NB_CTRL-1:0] BUBBLE_CTRL = '0,
    parameter int                 NB_CNT      = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               en_i,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [NB_DATA-1:0] in_data_i,
    input  logic [NB_CTRL-1:0] in_ctrl_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [NB_DATA-1:0] out_data_o,
    output logic [NB_CTRL-1:0] out_ctrl_o,
    input  logic               clr_stats_i,
    output logic [NB_CNT-1:0]  stall_cnt_o,
    output logic [NB_CNT-1:0]  bubble_cnt_o
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t             state_q;
    logic [NB_DATA-1:0] main_data_q, skid_data_q;
    logic [NB_CTRL-1:0] main_ctrl_q, skid_ctrl_q;
    logic               accept, drain;
    assign in_ready_o  = en_i & ~flush_i & ~reset & (state_q != FULL);
    assign out_valid_o = en_i & (state_q != EMPTY);
    assign accept      = in_valid_i & in_ready_o;
    assign drain       = out_valid_o & out_ready_i;
    assign out_data_o  = main_data_q;
    assign out_ctrl_o  = out_valid_o ? main_ctrl_q : BUBBLE_CTRL;
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else if (flush_i) begin
            state_q <= EMPTY;
        end else if (en_i) begin
            case (state_q)
                EMPTY: if (accept) begin
                    state_q     <= ONE;
                    main_data_q <= in_data_i;
                    main_ctrl_q <= in_ctrl_i;
                end
                ONE: if (accept && drain) begin
                    main_data_q <= in_data_i;
                    main_ctrl_q <= in_ctrl_i;
                end else if (accept) begin
                    state_q     <= FULL;
                    skid_data_q <= in_data_i;
                    skid_ctrl_q <= in_ctrl_i;
                end else if (drain) begin
                    state_q <= EMPTY;
                end
                // Skid entry moves to the head so FIFO order is preserved.
                FULL: if (drain) begin
                    state_q     <= ONE;
                    main_data_q <= skid_data_q;
                    main_ctrl_q <= skid_ctrl_q;
                end
                default: state_q <= EMPTY;
            endcase
        end
    end
`ifdef PIPE_STAGE_BUFFER_STATS_EN
    logic [NB_CNT-1:0] stall_cnt_q, bubble_cnt_q;
    logic              stall, bubble;
    assign stall  = out_valid_o & ~out_ready_i;
    assign bubble = en_i & ~out_valid_o;
    always_ff @(posedge clock) begin
        if (reset || clr_stats_i) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (stall && ~&stall_cnt_q) stall_cnt_q <= stall_cnt_q + NB_CNT'(1);
            if (bubble && ~&bubble_cnt_q) bubble_cnt_q <= bubble_cnt_q + NB_CNT'(1);
        end
    end
    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`else
    logic unused_clr_stats;
    assign unused_clr_stats = clr_stats_i;
    assign stall_cnt_o      = '0;
    assign bubble_cnt_o     = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_buffer.sv
// tb_pipe_stage_buffer: directed scenarios plus random traffic checked against a FIFO-level model.
module tb_pipe_stage_buffer;
    localparam int                 NB_DATA = 64;
    localparam int                 NB_CTRL = 12;
    localparam int                 NB_CNT  = 4;
    localparam logic [NB_CTRL-1:0] BUB     = 12'h5A5;
    localparam logic               H       = 1'b1;
    localparam logic               L       = 1'b0;

    logic               clock = 1'b0;
    logic               reset, en_i, flush_i, in_valid_i, out_ready_i, clr_stats_i;
    logic               in_ready_o, out_valid_o;
    logic [NB_DATA-1:0] in_data_i, out_data_o;
    logic [NB_CTRL-1:0] in_ctrl_i, out_ctrl_o;
    logic [NB_CNT-1:0]  stall_cnt_o, bubble_cnt_o;

    pipe_stage_buffer #(.NB_DATA(NB_DATA), .NB_CTRL(NB_CTRL), .BUBBLE_CTRL(BUB), .NB_CNT(NB_CNT)) dut (
        .clock(clock), .reset(reset), .en_i(en_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i), .in_ctrl_i(in_ctrl_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o), .out_ctrl_o(out_ctrl_o),
        .clr_stats_i(clr_stats_i), .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [NB_DATA-1:0] d;
        logic [NB_CTRL-1:0] c;
    } ent_t;

    ent_t               exp_q[$];
    int                 checks = 0;
    int                 errors = 0;
    logic               armed = 1'b0;
    logic [NB_DATA-1:0] stale = '0;
    logic [NB_CNT-1:0]  stall_m = '0;
    logic [NB_CNT-1:0]  bubble_m = '0;

    task automatic chk(input string name, input logic [NB_DATA-1:0] act, input logic [NB_DATA-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor and reference model: the stage behaves as a 2-deep FIFO sampled mid-cycle.
    always @(negedge clock) begin : mon
        logic ev, er;
        ent_t e;
        if (armed) begin
            ev = en_i && exp_q.size() > 0;
            er = en_i && !flush_i && !reset && exp_q.size() < 2;
            chk("in_ready", NB_DATA'(in_ready_o), NB_DATA'(er));
            chk("out_valid", NB_DATA'(out_valid_o), NB_DATA'(ev));
            chk("out_ctrl", NB_DATA'(out_ctrl_o), NB_DATA'(ev ? exp_q[0].c : BUB));
            chk("out_data", out_data_o, stale);
`ifdef PIPE_STAGE_BUFFER_STATS_EN
            chk("stall_cnt", NB_DATA'(stall_cnt_o), NB_DATA'(stall_m));
            chk("bubble_cnt", NB_DATA'(bubble_cnt_o), NB_DATA'(bubble_m));
`else
            chk("stall_cnt", NB_DATA'(stall_cnt_o), '0);
            chk("bubble_cnt", NB_DATA'(bubble_cnt_o), '0);
`endif
            if (out_valid_o === 1'b1 && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h expected none at %0t", out_data_o, $time);
                end else begin
                    chk("pop_data", out_data_o, exp_q[0].d);
                    chk("pop_ctrl", NB_DATA'(out_ctrl_o), NB_DATA'(exp_q[0].c));
                end
            end
            if (reset) begin
                exp_q.delete();
                stale    = '0;
                stall_m  = '0;
                bubble_m = '0;
            end else begin
                if (clr_stats_i) begin
                    stall_m  = '0;
                    bubble_m = '0;
                end else begin
                    if (ev && !out_ready_i && stall_m != '1) stall_m++;
                    if (en_i && !ev && bubble_m != '1) bubble_m++;
                end
                if (flush_i) exp_q.delete();
                else if (en_i) begin
                    if (ev && out_ready_i) void'(exp_q.pop_front());
                    if (er && in_valid_i) begin
                        e.d = in_data_i;
                        e.c = in_ctrl_i;
                        exp_q.push_back(e);
                    end
                end
                if (exp_q.size() > 0) stale = exp_q[0].d;
            end
        end
    end

    task automatic drv(input logic r, input logic e, input logic f, input logic v, input logic o,
                       input logic c, input logic [NB_DATA-1:0] d, input logic [NB_CTRL-1:0] k);
        reset = r; en_i = e; flush_i = f; in_valid_i = v; out_ready_i = o; clr_stats_i = c;
        in_data_i = d; in_ctrl_i = k;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; en_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        clr_stats_i = 1'b0; in_data_i = '0; in_ctrl_i = '0;
        @(posedge clock);
        #1;
        armed = 1'b1;
        drv(H, H, L, L, H, L, '0, '0);
        // back-to-back stream
        for (int i = 1; i <= 8; i++) drv(L, H, L, H, H, L, NB_DATA'(i), NB_CTRL'(i));
        repeat (2) drv(L, H, L, L, H, L, '0, '0);
        // skid capture and in-order release
        drv(L, H, L, H, L, L, 'hA, 12'h001);
        drv(L, H, L, H, L, L, 'hB, 12'h002);
        repeat (3) drv(L, H, L, H, L, L, 'hC, 12'h003);
        repeat (2) drv(L, H, L, H, H, L, 'hC, 12'h003);
        repeat (3) drv(L, H, L, L, H, L, '0, '0);
        // flush while full with a concurrent offer
        drv(L, H, L, H, L, L, 'hA, 12'h011);
        drv(L, H, L, H, L, L, 'hB, 12'h012);
        drv(L, H, H, H, L, L, 'hD, 12'h014);
        drv(L, H, L, H, H, L, 'hD, 12'h014);
        repeat (2) drv(L, H, L, L, H, L, '0, '0);
        // freeze holding an entry
        drv(L, H, L, H, L, L, 'hA, 12'hABC);
        repeat (5) drv(L, L, L, H, H, L, 'hE, 12'h005);
        repeat (2) drv(L, H, L, L, H, L, '0, '0);
        // reset while full, then resume
        drv(L, H, L, H, L, L, 'h21, 12'h021);
        drv(L, H, L, H, L, L, 'h22, 12'h022);
        drv(H, H, L, H, H, L, 'h23, 12'h023);
        for (int i = 0; i < 4; i++) drv(L, H, L, H, H, L, NB_DATA'(32'h30 + i), NB_CTRL'(i));
        drv(L, H, L, L, H, L, '0, '0);
        // long stall to saturate, then clear
        drv(L, H, L, H, L, L, 'h40, 12'h040);
        repeat (20) drv(L, H, L, L, L, L, '0, '0);
        drv(L, H, L, L, L, H, '0, '0);
        repeat (2) drv(L, H, L, L, H, L, '0, '0);
        // random traffic
        for (int i = 0; i < 3000; i++)
            drv($urandom_range(99) == 0, $urandom_range(9) != 0, $urandom_range(15) == 0,
                $urandom_range(3) != 0, $urandom_range(2) != 0, $urandom_range(49) == 0,
                {$urandom(), $urandom()}, NB_CTRL'($urandom()));
        drv(L, H, L, L, H, L, '0, '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
